// File: rtl/onehot_addr_sequencer_pkg.sv
// Shared constants and FSM encoding for the one-hot slot-address sequencer.
package onehot_addr_sequencer_pkg;
    localparam int          NSLOT       = 15;
    localparam int          IDXW        = 4;
    localparam logic [3:0]  INVALID_IDX = 4'hf;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;
endpackage

// File: rtl/onehot_addr_sequencer_onehot_decode.sv
// Combinational binary slot index to one-hot select: slot 0 -> bit 14, slot k -> bit k-1, 15 -> none.
module onehot_decode
    import onehot_addr_sequencer_pkg::*;
(
    input  logic [IDXW-1:0]  idx,
    output logic [NSLOT-1:0] onehot
);
    always_comb begin
        onehot = '0;
        if (idx == '0)
            onehot[NSLOT-1] = 1'b1;
        else if (idx < IDXW'(NSLOT))
            onehot[idx - IDXW'(1)] = 1'b1;
    end
endmodule

// File: rtl/onehot_addr_sequencer.sv
// Walks len one-hot slot selects from first (wrapping 14->0), one per handshake, then pulses done.
// Optional ADDR_BIN_EN adds a registered binary index output addr_bin.
module onehot_addr_sequencer
    import onehot_addr_sequencer_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [IDXW-1:0]   first,
    input  logic [IDXW-1:0]   len,
    input  logic              addr_ready,
    output logic              addr_valid,
    output logic [NSLOT-1:0]  addr_onehot,
    output logic              addr_last,
`ifdef ADDR_BIN_EN
    output logic [IDXW-1:0]   addr_bin,
`endif
    output logic              busy,
    output logic              done
);
    state_t            state, state_n;
    logic [IDXW-1:0]   idx, idx_n;
    logic [IDXW-1:0]   cnt, cnt_n;
    logic [NSLOT-1:0]  onehot_n;

    always_comb begin
        state_n = state;
        idx_n   = idx;
        cnt_n   = cnt;
        case (state)
            S_IDLE: begin
                if (start) begin
                    if (len != '0) begin
                        state_n = S_RUN;
                        idx_n   = (first == INVALID_IDX) ? '0 : first;
                        cnt_n   = len;
                    end else begin
                        state_n = S_DONE;
                    end
                end
            end
            S_RUN: begin
                if (addr_valid && addr_ready) begin
                    idx_n = (idx == IDXW'(NSLOT - 1)) ? '0 : idx + IDXW'(1);
                    cnt_n = cnt - IDXW'(1);
                    if (cnt == IDXW'(1))
                        state_n = S_DONE;
                end
            end
            S_DONE:  state_n = S_IDLE;
            default: state_n = S_IDLE;
        endcase
    end

    onehot_decode u_decode (
        .idx    (idx_n),
        .onehot (onehot_n)
    );

    // Outputs are registered from next-state values so the beat appears the cycle after start.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= S_IDLE;
            idx         <= '0;
            cnt         <= '0;
            addr_valid  <= 1'b0;
            addr_onehot <= '0;
            addr_last   <= 1'b0;
            busy        <= 1'b0;
            done        <= 1'b0;
        end else begin
            state       <= state_n;
            idx         <= idx_n;
            cnt         <= cnt_n;
            addr_valid  <= (state_n == S_RUN);
            addr_onehot <= (state_n == S_RUN) ? onehot_n : '0;
            addr_last   <= (state_n == S_RUN) && (cnt_n == IDXW'(1));
            busy        <= (state_n != S_IDLE);
            done        <= (state_n == S_DONE);
        end
    end

`ifdef ADDR_BIN_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            addr_bin <= INVALID_IDX;
        else
            addr_bin <= (state_n == S_RUN) ? idx_n : INVALID_IDX;
    end
`endif
endmodule

// File: tb/tb_onehot_addr_sequencer.sv
// Scoreboard bench: stimulus queues the expected beats, a negedge monitor checks every presented beat.
module tb_onehot_addr_sequencer;
    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [3:0]  first;
    logic [3:0]  len;
    logic        addr_ready;
    logic        addr_valid;
    logic [14:0] addr_onehot;
    logic        addr_last;
    logic        busy;
    logic        done;
`ifdef ADDR_BIN_EN
    logic [3:0]  addr_bin;
`endif

    onehot_addr_sequencer dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .first       (first),
        .len         (len),
        .addr_ready  (addr_ready),
        .addr_valid  (addr_valid),
        .addr_onehot (addr_onehot),
        .addr_last   (addr_last),
`ifdef ADDR_BIN_EN
        .addr_bin    (addr_bin),
`endif
        .busy        (busy),
        .done        (done)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [14:0] oh;
        logic        last;
        logic [3:0]  bin;
    } beat_t;

    beat_t q[$];
    int checks   = 0;
    int failures = 0;
    int ndone    = 0;
    int exp_done = 0;
    int nbeats   = 0;
    logic prev_done = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference: beat i of a sequence selects slot (start+i) mod 15; slot s drives bit (s+14) mod 15.
    task automatic push_expected(input int f, input int l);
        int s0;
        s0 = (f == 15) ? 0 : f;
        for (int i = 0; i < l; i++) begin
            beat_t b;
            int s;
            s      = (s0 + i) % 15;
            b.oh   = 15'(1) << ((s + 14) % 15);
            b.last = (i == l - 1);
            b.bin  = 4'(s);
            q.push_back(b);
        end
    endtask

    always @(negedge clk) begin
        if (!rst) begin
            if (addr_valid) begin
                if (q.size() == 0) begin
                    chk("unexpected_beat", {17'd0, addr_onehot}, 32'd0);
                end else begin
                    chk("beat_onehot", {17'd0, addr_onehot}, {17'd0, q[0].oh});
                    chk("beat_last", {31'd0, addr_last}, {31'd0, q[0].last});
`ifdef ADDR_BIN_EN
                    chk("beat_bin", {28'd0, addr_bin}, {28'd0, q[0].bin});
`endif
                    if (addr_ready) begin
                        void'(q.pop_front());
                        nbeats++;
                    end
                end
            end else begin
                chk("idle_onehot_zero", {17'd0, addr_onehot}, 32'd0);
`ifdef ADDR_BIN_EN
                chk("idle_bin_invalid", {28'd0, addr_bin}, 32'hf);
`endif
            end
            if (done) begin
                chk("done_after_all_beats", q.size(), 0);
                chk("done_single_cycle", {31'd0, prev_done}, 32'd0);
                ndone++;
            end
            prev_done = done;
        end else begin
            prev_done = 1'b0;
        end
    end

    // One sequence; ready is high with probability prob percent each cycle.
    task automatic run_seq(input int f, input int l, input int prob, input bit inject);
        int cyc;
        @(posedge clk); #1;
        first = 4'(f); len = 4'(l); start = 1'b1;
        push_expected(f, l);
        exp_done++;
        cyc = 0;
        do begin
            @(posedge clk); #1;
            start = 1'b0;
            if (inject && cyc == 1) begin
                start = 1'b1; first = 4'd3; len = 4'd7;
            end
            addr_ready = ($urandom_range(0, 99) < prob);
            cyc++;
        end while (ndone < exp_done && cyc < 500);
        start = 1'b0;
        chk("seq_done_seen", ndone, exp_done);
        chk("idle_after_done_busy", {31'd0, busy}, 32'd0);
        chk("idle_after_done_valid", {31'd0, addr_valid}, 32'd0);
        q.delete();
        ndone = exp_done;
    endtask

    initial begin
        int base, cyc;
        rst = 1'b1; start = 1'b0; first = '0; len = '0; addr_ready = 1'b0;
        #3;
        chk("reset_valid", {31'd0, addr_valid}, 32'd0);
        chk("reset_onehot", {17'd0, addr_onehot}, 32'd0);
        chk("reset_busy_done", {30'd0, busy, done}, 32'd0);
`ifdef ADDR_BIN_EN
        chk("reset_bin", {28'd0, addr_bin}, 32'hf);
`endif
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;

        run_seq(0, 3, 100, 1'b0);
        run_seq(13, 4, 100, 1'b0);
        run_seq(5, 2, 30, 1'b0);
        run_seq(7, 0, 100, 1'b0);
        run_seq(15, 2, 100, 1'b0);
        run_seq(9, 2, 100, 1'b1);

        // Abort a len=6 run after its second accepted beat.
        base = nbeats;
        @(posedge clk); #1;
        first = 4'd2; len = 4'd6; start = 1'b1; addr_ready = 1'b1;
        push_expected(2, 6);
        @(posedge clk); #1 start = 1'b0;
        cyc = 0;
        while (nbeats < base + 2 && cyc < 50) begin
            @(negedge clk); #1;
            cyc++;
        end
        chk("abort_two_beats", nbeats - base, 2);
        rst = 1'b1;
        #1;
        chk("abort_valid", {31'd0, addr_valid}, 32'd0);
        chk("abort_onehot", {17'd0, addr_onehot}, 32'd0);
        chk("abort_busy_done", {30'd0, busy, done}, 32'd0);
        q.delete();
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        repeat (8) @(posedge clk);
        chk("abort_no_done", ndone, exp_done);

        for (int i = 0; i < 40; i++)
            run_seq($urandom_range(0, 15), $urandom_range(0, 15), $urandom_range(30, 100), 1'b0);

        repeat (3) @(posedge clk);
        chk("final_done_count", ndone, exp_done);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
